// File: rtl/sd_spi_cmd_framer_pkg.sv
// Shared types and constants for the SD SPI-mode command framer.
package sd_spi_cmd_framer_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned IDX_W       = 6;
   localparam int unsigned ARG_W       = 32;
   localparam int unsigned CRC_W       = 7;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned NCR_W       = 8;
   localparam int unsigned FRAME_BYTES = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_CHECK,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_SEND,
      ST_R1OUT
   } state_t;

   // R1 response bit positions
   localparam int unsigned R1_IDLE_BIT    = 0;
   localparam int unsigned R1_ILL_CMD_BIT = 2;
   localparam int unsigned R1_COM_CRC_BIT = 3;

   localparam logic [CRC_W-1:0]  CRC7_POLY      = 7'h09;
   localparam logic [BYTE_W-1:0] IDLE_FILL      = 8'hFF;
   localparam logic [BYTE_W-1:0] R1_COM_CRC_ERR = 8'h01 << R1_COM_CRC_BIT;

endpackage

// File: rtl/sd_spi_cmd_framer_crc7.sv
// sd_crc7: one-byte MSB-first CRC7 update (x^7+x^3+1), purely combinational.
module sd_crc7
   import sd_spi_cmd_framer_pkg::*;
(
   input  logic [CRC_W-1:0]  crc_in,
   input  logic [BYTE_W-1:0] data_byte,
   output logic [CRC_W-1:0]  crc_out
);

   logic [CRC_W-1:0] crc;
   logic             fb;

   always_comb begin
      crc = crc_in;
      fb  = 1'b0;
      for (int i = BYTE_W - 1; i >= 0; i--) begin
         fb  = crc[CRC_W-1] ^ data_byte[i];
         crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
      crc_out = crc;
   end

endmodule

// File: rtl/sd_spi_cmd_framer.sv
// Frames SD SPI-mode 6-byte commands from the SPI slave byte stream and returns R1 on MISO.
// Define SD_CRC_CHECK_EN to verify CRC7 on received frames; otherwise only the end bit is checked.
module sd_spi_cmd_framer
   import sd_spi_cmd_framer_pkg::*;
#(
   parameter int unsigned NCR_MAX = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ssel_n,
   input  logic [BYTE_W-1:0] rx_byte,
   input  logic              rx_valid,
   output logic [BYTE_W-1:0] tx_byte,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [IDX_W-1:0]  cmd_idx,
   output logic [ARG_W-1:0]  cmd_arg,
   input  logic              rsp_valid,
   input  logic [BYTE_W-1:0] rsp_r1,
   output logic              rsp_timeout
);

`ifdef SD_CRC_CHECK_EN
   localparam bit CRC_CHECK = 1'b1;
`else
   localparam bit CRC_CHECK = 1'b0;
`endif
   localparam logic [NCR_W-1:0] NCR_LIMIT = NCR_W'(NCR_MAX);

   state_t            state_q, state_d;
   logic [BYTE_W-1:0] tx_q, tx_d, pending_q, pending_d, last_q, last_d;
   logic              cmd_valid_q, cmd_valid_d, timeout_q, timeout_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ARG_W-1:0]  arg_q, arg_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [NCR_W-1:0]  ncr_q, ncr_d;
   logic [CRC_W-1:0]  crc_q, crc_d, crc_seed_c, crc_next_c;
   logic              frame_ok_c, ncr_hit_c;

   // A new frame restarts the CRC from zero on its start byte.
   assign crc_seed_c = (state_q == ST_IDLE) ? '0 : crc_q;

   sd_crc7 u_crc7 (
      .crc_in    (crc_seed_c),
      .data_byte (rx_byte),
      .crc_out   (crc_next_c)
   );

   assign frame_ok_c = last_q[0] && (!CRC_CHECK || (last_q[7:1] == crc_q));
   assign ncr_hit_c  = (ncr_q + NCR_W'(1)) == NCR_LIMIT;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         tx_q        <= IDLE_FILL;
         cmd_valid_q <= 1'b0;
         idx_q       <= '0;
         arg_q       <= '0;
         timeout_q   <= 1'b0;
         byte_cnt_q  <= '0;
         ncr_q       <= '0;
         pending_q   <= IDLE_FILL;
         last_q      <= '0;
         crc_q       <= '0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         cmd_valid_q <= cmd_valid_d;
         idx_q       <= idx_d;
         arg_q       <= arg_d;
         timeout_q   <= timeout_d;
         byte_cnt_q  <= byte_cnt_d;
         ncr_q       <= ncr_d;
         pending_q   <= pending_d;
         last_q      <= last_d;
         crc_q       <= crc_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      cmd_valid_d = cmd_valid_q;
      idx_d       = idx_q;
      arg_d       = arg_q;
      timeout_d   = 1'b0;
      byte_cnt_d  = byte_cnt_q;
      ncr_d       = ncr_q;
      pending_d   = pending_q;
      last_d      = last_q;
      crc_d       = crc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid && (rx_byte[7:6] == 2'b01)) begin
               idx_d      = rx_byte[5:0];
               arg_d      = '0;
               crc_d      = CRC_CHECK ? crc_next_c : '0;
               byte_cnt_d = CNT_W'(1);
               state_d    = ST_CMD;
            end
         end
         ST_CMD: begin
            if (ssel_n) begin
               byte_cnt_d = '0;
               state_d    = ST_IDLE;
            end else if (rx_valid) begin
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                  last_d  = rx_byte;
                  state_d = ST_CHECK;
               end else begin
                  arg_d = {arg_q[ARG_W-BYTE_W-1:0], rx_byte};
                  if (CRC_CHECK) crc_d = crc_next_c;
               end
            end
         end
         ST_CHECK: begin
            byte_cnt_d = '0;
            ncr_d      = '0;
            if (frame_ok_c) begin
               cmd_valid_d = 1'b1;
               state_d     = ST_ISSUE;
            end else begin
               pending_d = R1_COM_CRC_ERR;
               state_d   = ST_SEND;
            end
         end
         ST_ISSUE: begin
            // Chip select is deliberately ignored here so the core handshake is never torn.
            if (rx_valid) ncr_d = ncr_q + NCR_W'(1);
            if (rx_valid && ncr_hit_c) begin
               timeout_d   = 1'b1;
               cmd_valid_d = 1'b0;
               tx_d        = IDLE_FILL;
               state_d     = ST_IDLE;
            end else if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            tx_d = IDLE_FILL;
            if (ssel_n) begin
               state_d = ST_IDLE;
            end else if (rsp_valid) begin
               if (rx_valid) begin
                  tx_d    = rsp_r1;
                  state_d = ST_R1OUT;
               end else begin
                  pending_d = rsp_r1;
                  state_d   = ST_SEND;
               end
            end else if (rx_valid) begin
               ncr_d = ncr_q + NCR_W'(1);
               if (ncr_hit_c) begin
                  timeout_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_SEND: begin
            if (ssel_n) begin
               tx_d    = IDLE_FILL;
               state_d = ST_IDLE;
            end else if (rx_valid) begin
               tx_d    = pending_q;
               state_d = ST_R1OUT;
            end
         end
         ST_R1OUT: begin
            if (ssel_n || rx_valid) begin
               tx_d    = IDLE_FILL;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tx_byte     = tx_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_idx     = idx_q;
   assign cmd_arg     = arg_q;
   assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_sd_spi_cmd_framer.sv
// Self-checking bench for sd_spi_cmd_framer: vector table of frames plus hand-written corner sequences.
module tb_sd_spi_cmd_framer;

   localparam int unsigned NCR_MAX = 8;
   localparam int unsigned NVEC    = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        ssel_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [7:0]  tx_byte;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg;
   logic        rsp_valid;
   logic [7:0]  rsp_r1;
   logic        rsp_timeout;

   sd_spi_cmd_framer #(.NCR_MAX(NCR_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .ssel_n      (ssel_n),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .tx_byte     (tx_byte),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_idx     (cmd_idx),
      .cmd_arg     (cmd_arg),
      .rsp_valid   (rsp_valid),
      .rsp_r1      (rsp_r1),
      .rsp_timeout (rsp_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] arg;
   } cmd_t;

   typedef struct {
      logic [47:0] frame;
      bit          accept;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  r1;
      int          dly;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   cmd_t cmd_q[$];
   logic [7:0] tx_q[$];
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One byte slot: expected MISO byte queued with the stimulus, compared after the boundary.
   task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_tx,
                            input bit with_rsp = 1'b0, input logic [7:0] r1 = 8'hFF);
      tick();
      rx_byte  = b;
      rx_valid = 1'b1;
      if (with_rsp) begin
         rsp_valid = 1'b1;
         rsp_r1    = r1;
      end
      tx_q.push_back(exp_tx);
      tick();
      rx_valid  = 1'b0;
      rsp_valid = 1'b0;
      chk("tx_byte", 32'(tx_byte), 32'(tx_q.pop_front()));
   endtask

   task automatic send_frame(input logic [47:0] f);
      logic [7:0] b;
      for (int i = 5; i >= 0; i--) begin
         b = f[i*8 +: 8];
         send_byte(b, 8'hFF);
      end
   endtask

   task automatic wait_cmd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("cmd_valid_rise", 32'(ok), 32'd1);
   endtask

   task automatic accept(input logic [5:0] idx, input logic [31:0] arg, input int dly);
      bit ok;
      wait_cmd(ok);
      if (ok) begin
         cmd_q.push_back({idx, arg});
         for (int i = 0; i < dly; i++) begin
            tick();
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_idx", 32'(cmd_idx), 32'(idx));
            chk("hold_arg", cmd_arg, arg);
         end
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
         chk("valid_drop", 32'(cmd_valid), 32'd0);
      end
   endtask

   task automatic pulse_rsp(input logic [7:0] r1);
      tick();
      rsp_valid = 1'b1;
      rsp_r1    = r1;
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic finish_rsp(input logic [7:0] r1);
      send_byte(8'hFF, 8'hFF);
      pulse_rsp(r1);
      send_byte(8'hFF, r1);
      send_byte(8'hFF, 8'hFF);
   endtask

   // Command scoreboard: every accepted handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && cmd_valid && cmd_ready) begin
         if (cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cmd actual idx=%0h arg=%0h required none", cmd_idx, cmd_arg);
         end else begin
            cmd_t e;
            e = cmd_q.pop_front();
            chk("cmd_idx", 32'(cmd_idx), 32'(e.idx));
            chk("cmd_arg", cmd_arg, e.arg);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      vecs[0] = '{48'h400000000095, 1'b1, 6'd0,  32'h00000000, 8'h01, 0};
      vecs[1] = '{48'h48000001AA87, 1'b1, 6'd8,  32'h000001AA, 8'h01, 3};
      vecs[2] = '{48'h770000000065, 1'b1, 6'd55, 32'h00000000, 8'h01, 1};
      vecs[3] = '{48'h694000000077, 1'b1, 6'd41, 32'h40000000, 8'h00, 0};
      vecs[4] = '{48'h400000000094, 1'b0, 6'd0,  32'h00000000, 8'h08, 0};
      vecs[5] = '{48'h48000001AA86, 1'b0, 6'd8,  32'h000001AA, 8'h08, 0};
`ifdef SD_CRC_CHECK_EN
      vecs[6] = '{48'h400000000097, 1'b0, 6'd0,  32'h00000000, 8'h08, 0};
`else
      vecs[6] = '{48'h400000000097, 1'b1, 6'd0,  32'h00000000, 8'h05, 0};
`endif

      ssel_n    = 1'b0;
      rx_byte   = 8'hFF;
      rx_valid  = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_r1    = 8'h00;
      rst       = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("rst_tx", 32'(tx_byte), 32'hFF);
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_idx", 32'(cmd_idx), 32'd0);
      chk("rst_arg", cmd_arg, 32'd0);
      chk("rst_timeout", 32'(rsp_timeout), 32'd0);
      repeat (2) tick();
      rst = 1'b1;

      send_byte(8'hFF, 8'hFF);
      send_byte(8'hFF, 8'hFF);

      for (int v = 0; v < int'(NVEC); v++) begin
         send_byte(8'hC8, 8'hFF);
         send_frame(vecs[v].frame);
         if (vecs[v].accept) begin
            accept(vecs[v].idx, vecs[v].arg, vecs[v].dly);
            finish_rsp(vecs[v].r1);
         end else begin
            tick();
            chk("reject_no_cmd", 32'(cmd_valid), 32'd0);
            send_byte(8'hFF, vecs[v].r1);
            send_byte(8'hFF, 8'hFF);
         end
      end

      // Response arriving in the same cycle as a byte boundary goes out on that boundary.
      send_frame(48'h400000000095);
      accept(6'd0, 32'd0, 0);
      send_byte(8'hFF, 8'h01, 1'b1, 8'h01);
      send_byte(8'hFF, 8'hFF);

      // NCR expiry while waiting for the core response; a late response is dropped.
      send_frame(48'h400000000095);
      accept(6'd0, 32'd0, 0);
      for (int i = 0; i < int'(NCR_MAX) - 1; i++) begin
         send_byte(8'hFF, 8'hFF);
         chk("ncr_no_timeout", 32'(rsp_timeout), 32'd0);
      end
      send_byte(8'hFF, 8'hFF);
      chk("ncr_timeout_pulse", 32'(rsp_timeout), 32'd1);
      tick();
      chk("ncr_timeout_single", 32'(rsp_timeout), 32'd0);
      pulse_rsp(8'h01);
      send_byte(8'hFF, 8'hFF);
      send_byte(8'hFF, 8'hFF);

      // NCR expiry while the core never accepts.
      send_frame(48'h400000000095);
      wait_cmd(ok);
      for (int i = 0; i < int'(NCR_MAX) - 1; i++) send_byte(8'hFF, 8'hFF);
      chk("issue_still_valid", 32'(cmd_valid), 32'd1);
      send_byte(8'hFF, 8'hFF);
      chk("issue_timeout_pulse", 32'(rsp_timeout), 32'd1);
      chk("issue_timeout_drop", 32'(cmd_valid), 32'd0);
      send_byte(8'hFF, 8'hFF);

      // Deselect mid-frame, then a complete frame after reselect.
      send_byte(8'h40, 8'hFF);
      send_byte(8'h00, 8'hFF);
      send_byte(8'h00, 8'hFF);
      tick();
      ssel_n = 1'b1;
      repeat (2) tick();
      ssel_n = 1'b0;
      send_frame(48'h48000001AA87);
      accept(6'd8, 32'h000001AA, 0);
      finish_rsp(8'h01);

      // Deselect while waiting for the response drops it.
      send_frame(48'h400000000095);
      accept(6'd0, 32'd0, 0);
      tick();
      ssel_n = 1'b1;
      tick();
      ssel_n = 1'b0;
      pulse_rsp(8'h01);
      send_byte(8'hFF, 8'hFF);
      send_byte(8'hFF, 8'hFF);

      // Asynchronous reset while a command is presented.
      send_frame(48'h48000001AA87);
      wait_cmd(ok);
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(cmd_valid), 32'd0);
      chk("arst_idx", 32'(cmd_idx), 32'd0);
      chk("arst_arg", cmd_arg, 32'd0);
      chk("arst_tx", 32'(tx_byte), 32'hFF);
      tick();
      rst = 1'b1;

      // Asynchronous reset while R1 is on the wire.
      send_frame(48'h400000000095);
      accept(6'd0, 32'd0, 0);
      send_byte(8'hFF, 8'hFF);
      pulse_rsp(8'h01);
      send_byte(8'hFF, 8'h01);
      #1 rst = 1'b0;
      #1;
      chk("arst_r1_tx", 32'(tx_byte), 32'hFF);
      tick();
      rst = 1'b1;

      send_frame(48'h770000000065);
      accept(6'd55, 32'd0, 0);
      finish_rsp(8'h00);

      tick();
      chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
